// File: rtl/bcd_score_bank.sv
// Multi-player BCD score keeper: rising-edge hit detection, per-channel BCD counters
// with wrap/saturate, and sticky winner flags at a programmable score.
module bcd_score_bank #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned WIN_SCORE   = 11
) (
    input  logic                              Clock,
    input  logic                              pointresetShot1,
    input  logic [NUM_PLAYERS-1:0]            hit,
    input  logic [NUM_PLAYERS-1:0]            clear,
    input  logic                              clear_all,
    output logic [NUM_PLAYERS*DIGITS*4-1:0]   score,
    output logic [NUM_PLAYERS-1:0]            inc_pulse,
    output logic [NUM_PLAYERS-1:0]            winner,
    output logic                              game_over
);

    localparam int unsigned W = DIGITS * 4;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  x;
        r = '0;
        x = v;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    logic [NUM_PLAYERS-1:0]   hit_q;
    logic [NUM_PLAYERS*W-1:0] score_q, score_d;
    logic [NUM_PLAYERS-1:0]   inc_q, inc_d;
    logic [NUM_PLAYERS-1:0]   winner_q, winner_d;
    logic [NUM_PLAYERS-1:0]   hit_edge;
    logic                     over;
    logic [W-1:0]             cur, nxt;
    logic                     carry;

    assign hit_edge = hit & ~hit_q;
    assign over     = |winner_q;

    always_comb begin
        score_d  = score_q;
        inc_d    = '0;
        winner_d = winner_q;
        cur      = '0;
        nxt      = '0;
        carry    = 1'b0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            cur   = score_q[p*W +: W];
            nxt   = cur;
            carry = 1'b1;
            // Ripple the carry up through the digits; carry left set means all 9s.
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (cur[d*4 +: 4] == 4'd9) begin
                        nxt[d*4 +: 4] = 4'd0;
                    end else begin
                        nxt[d*4 +: 4] = cur[d*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
            if (clear_all || clear[p]) begin
                score_d[p*W +: W] = '0;
            end else if (hit_edge[p] && !over && !(carry && (SATURATE != 0))) begin
                score_d[p*W +: W] = nxt;
                inc_d[p]          = 1'b1;
                if ((WIN_SCORE != 0) && (nxt == WIN_BCD)) begin
                    winner_d[p] = 1'b1;
                end
            end
        end
        if (clear_all) begin
            winner_d = '0;
        end
    end

    always_ff @(posedge Clock or posedge pointresetShot1) begin
        if (pointresetShot1) begin
            hit_q    <= '1;
            score_q  <= '0;
            inc_q    <= '0;
            winner_q <= '0;
        end else begin
            hit_q    <= hit;
            score_q  <= score_d;
            inc_q    <= inc_d;
            winner_q <= winner_d;
        end
    end

    assign score     = score_q;
    assign inc_pulse = inc_q;
    assign winner    = winner_q;
    assign game_over = over;

endmodule
